// File: rtl/ram_arbiter.sv
// ram_arbiter: a two-port arbiter and sequencer that sits in front of a single-port
// synchronous RAM.
//   - Port 0 is instruction fetch. Port 1 is data load/store.
//   - The winning command is registered onto the RAM pins.
//   - Read data comes back on a shared rdata bus, qualified by a one-cycle
//     rvalid0/rvalid1 pulse.
//   - Every output is registered, so there is no combinational path from a
//     req input to any output.
//
// Configuration macro: RAM_ARB_FIXED_PRIO_EN
//   defined     - fixed priority, port 0 always wins a tie.
//   undefined   - round-robin, the port that was not the last winner wins a tie.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   req0/1                   access request, held until the matching gnt is seen
//   we0/1, addr0/1, wdata0/1 command fields, stable while req is high
//   gnt0/1                   one-cycle pulse: request accepted
//   rvalid0/1                one-cycle pulse: rdata holds this port's read result
//   rdata                    shared read data
//   busy                     high whenever the sequencer is not idle
//   ram_we, ram_addr,
//   ram_data_in              registered command to the RAM
//   ram_data_out             RAM read data, valid the cycle after the address edge
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

    state_t            state, state_nx;
    logic              win, win_nx;      // 0 = port 0 owns the current access
    logic              pick;             // winner if a request is taken this cycle
    logic              gnt0_nx, gnt1_nx, rvalid0_nx, rvalid1_nx, busy_nx, ram_we_nx;
    logic [ADDR_W-1:0] ram_addr_nx;
    logic [DATA_W-1:0] ram_din_nx, rdata_nx;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic              last, last_nx;    // last winner; resets to 1 so port 0 wins the first tie
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win         <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            busy        <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            rdata       <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last        <= 1'b1;
`endif
        end else begin
            state       <= state_nx;
            win         <= win_nx;
            gnt0        <= gnt0_nx;
            gnt1        <= gnt1_nx;
            rvalid0     <= rvalid0_nx;
            rvalid1     <= rvalid1_nx;
            busy        <= busy_nx;
            ram_we      <= ram_we_nx;
            ram_addr    <= ram_addr_nx;
            ram_data_in <= ram_din_nx;
            rdata       <= rdata_nx;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last        <= last_nx;
`endif
        end
    end

    always_comb begin
        state_nx    = state;
        win_nx      = win;
        gnt0_nx     = 1'b0;
        gnt1_nx     = 1'b0;
        rvalid0_nx  = 1'b0;
        rvalid1_nx  = 1'b0;
        ram_we_nx   = 1'b0;
        ram_addr_nx = ram_addr;
        ram_din_nx  = ram_data_in;
        rdata_nx    = rdata;
`ifdef RAM_ARB_FIXED_PRIO_EN
        pick        = !req0;
`else
        last_nx     = last;
        pick        = (req0 && req1) ? !last : req1;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // Gnt is raised for the ACCESS cycle, together with the RAM command.
                    state_nx    = ACCESS;
                    win_nx      = pick;
                    gnt0_nx     = !pick;
                    gnt1_nx     = pick;
                    ram_we_nx   = pick ? we1 : we0;
                    ram_addr_nx = pick ? addr1 : addr0;
                    ram_din_nx  = pick ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_nx = ram_we ? IDLE : RDWAIT;
`ifndef RAM_ARB_FIXED_PRIO_EN
                last_nx  = win;
`endif
            end
            RDWAIT: begin
                rdata_nx   = ram_data_out;
                rvalid0_nx = !win;
                rvalid1_nx = win;
                state_nx   = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed self-checking bench for ram_arbiter.
//   - A behavioural 256x8 RAM drives ram_data_out.
//   - A transaction-level model predicts each access: the winner, the grant
//     cycle, the RAM command and the read data.
//   - The model is built from ref_mem, the last winner, and the tie rule.
module tb_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
    logic [7:0] rdata, ram_addr, ram_data_in, ram_data_out;

    int n_chk = 0;
    int n_fail = 0;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // The two grants must never pulse together, nor the two rvalids.
    always @(negedge clk) begin
        chk("gnt_excl", {31'd0, gnt0 & gnt1}, 0);
        chk("rvalid_excl", {31'd0, rvalid0 & rvalid1}, 0);
    end

    // Model state
    logic [7:0] ref_mem [256];
    int         last_win = 1;             // port 0 wins the first tie after reset
    logic       p_v [2];
    logic       p_we [2];
    logic [7:0] p_addr [2];
    logic [7:0] p_wd [2];

    task automatic drive();
        req0 = p_v[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
        req1 = p_v[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
    endtask

    task automatic set_req(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
        p_v[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
    endtask

    // Runs one arbitration round from IDLE.
    // Inputs are driven #1 after an edge; outputs are checked #1 after the next edges.
    task automatic run_one();
        int w;
        logic [7:0] exp_d;
        drive();
        if (!p_v[0] && !p_v[1]) begin
            @(posedge clk); #1;
            chk("idle_busy", {31'd0, busy}, 0);
            chk("idle_gnt", {30'd0, gnt1, gnt0}, 0);
            return;
        end
`ifdef RAM_ARB_FIXED_PRIO_EN
        w = p_v[0] ? 0 : 1;
`else
        if (p_v[0] && p_v[1]) w = (last_win == 0) ? 1 : 0;
        else                  w = p_v[0] ? 0 : 1;
`endif
        @(posedge clk); #1;
        chk("gnt0", {31'd0, gnt0}, {31'd0, w == 0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, w == 1});
        chk("busy_acc", {31'd0, busy}, 1);
        chk("ram_we", {31'd0, ram_we}, {31'd0, p_we[w]});
        chk("ram_addr", {24'd0, ram_addr}, {24'd0, p_addr[w]});
        if (p_we[w]) chk("ram_din", {24'd0, ram_data_in}, {24'd0, p_wd[w]});
        p_v[w] = 1'b0;
        drive();
        last_win = w;
        if (p_we[w]) begin
            ref_mem[p_addr[w]] = p_wd[w];
            @(posedge clk); #1;
            chk("wr_done_busy", {31'd0, busy}, 0);
            chk("wr_done_we", {31'd0, ram_we}, 0);
            chk("wr_no_rvalid", {30'd0, rvalid1, rvalid0}, 0);
        end else begin
            exp_d = ref_mem[p_addr[w]];
            @(posedge clk); #1;
            chk("rdw_busy", {31'd0, busy}, 1);
            chk("rdw_we", {31'd0, ram_we}, 0);
            chk("rdw_addr", {24'd0, ram_addr}, {24'd0, p_addr[w]});
            chk("rdw_rvalid", {30'd0, rvalid1, rvalid0}, 0);
            @(posedge clk); #1;
            chk("rvalid0", {31'd0, rvalid0}, {31'd0, w == 0});
            chk("rvalid1", {31'd0, rvalid1}, {31'd0, w == 1});
            chk("rdata", {24'd0, rdata}, {24'd0, exp_d});
            @(posedge clk); #1;
            chk("resp_done_busy", {31'd0, busy}, 0);
            chk("resp_done_rvalid", {30'd0, rvalid1, rvalid0}, 0);
            chk("rdata_hold", {24'd0, rdata}, {24'd0, exp_d});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {25'd0, gnt0, gnt1, rvalid0, rvalid1, busy, ram_we}, 0);
        chk({tag, "_addr"}, {24'd0, ram_addr}, 0);
        chk({tag, "_din"}, {24'd0, ram_data_in}, 0);
        chk({tag, "_rdata"}, {24'd0, rdata}, 0);
    endtask

    initial begin
        p_v[0] = 0; p_v[1] = 0;
        p_we[0] = 0; p_we[1] = 0;
        p_addr[0] = 0; p_addr[1] = 0;
        p_wd[0] = 0; p_wd[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Fill the whole RAM through both ports so that every read has a known expectation.
        for (int a = 0; a < 256; a++) begin
            set_req(a % 2, 1'b1, 8'(a), 8'($urandom));
            run_one();
        end

        // Reset in the middle of ACCESS: outputs clear at once, and a tie afterwards goes to port 0.
        set_req(0, 1'b1, 8'h55, 8'h99);
        drive();
        @(posedge clk); #1;
        chk("rst_pre_gnt0", {31'd0, gnt0}, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        p_v[0] = 0;
        drive();
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_win = 1;
        set_req(0, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b0, 8'h02, 8'h00);
        run_one();                                  // expects gnt0
        run_one();                                  // then port 1

        // Single write then read through port 1
        set_req(1, 1'b1, 8'h3C, 8'hA5); run_one();
        set_req(1, 1'b0, 8'h3C, 8'h00); run_one();
        chk("rd_3c", {24'd0, rdata}, 32'hA5);

        // Tie with both requests held: grants alternate under round-robin
        for (int i = 0; i < 6; i++) begin
            if (!p_v[0]) set_req(0, 1'b0, 8'h01, 8'h00);
            if (!p_v[1]) set_req(1, 1'b0, 8'h02, 8'h00);
            run_one();
        end
        p_v[0] = 0; p_v[1] = 0;
        run_one();

        // Cancellation case 1: req0 pulses between two idle edges and must be ignored.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h77; wdata0 = 8'h5A;
        #2 req0 = 1'b0;
        @(posedge clk); #1;
        chk("glitch_busy", {31'd0, busy}, 0);
        chk("glitch_gnt0", {31'd0, gnt0}, 0);

        // Cancellation case 2: req0 is raised while busy and dropped before idle, so it must be ignored.
        set_req(1, 1'b1, 8'h40, 8'h3E);
        drive();
        @(posedge clk); #1;
        chk("cx_gnt1", {31'd0, gnt1}, 1);
        p_v[1] = 0; drive();
        ref_mem[8'h40] = 8'h3E;
        last_win = 1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h77; wdata0 = 8'h5A;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        chk("cx_busy", {31'd0, busy}, 0);
        chk("cx_gnt0", {31'd0, gnt0}, 0);
        set_req(1, 1'b0, 8'h77, 8'h00); run_one();  // location 0x77 must keep its old contents
        set_req(0, 1'b0, 8'h40, 8'h00);
        set_req(1, 1'b0, 8'h41, 8'h00);
        run_one();                                  // the tie should go to port 0 (the pointer did not move)
        run_one();

        // Boundary addresses, written from different ports
        set_req(0, 1'b1, 8'h00, 8'h11); run_one();
        set_req(1, 1'b1, 8'hFF, 8'hEE); run_one();
        set_req(1, 1'b0, 8'h00, 8'h00); run_one();
        chk("rd_00", {24'd0, rdata}, 32'h11);
        set_req(0, 1'b0, 8'hFF, 8'h00); run_one();
        chk("rd_ff", {24'd0, rdata}, 32'hEE);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_v[p] && ($urandom_range(0, 9) < 6)) begin
                    logic [7:0] a;
                    case ($urandom_range(0, 3))
                        0:       a = 8'h00;
                        1:       a = 8'hFF;
                        default: a = 8'($urandom);
                    endcase
                    set_req(p, 1'($urandom), a, 8'($urandom));
                end
            end
            run_one();
        end
        p_v[0] = 0; p_v[1] = 0;
        run_one();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
